// File: rtl/wb_pkg.sv
// Shared constants for the write-back controller: arbitration modes and default widths.
package wb_pkg;
   localparam int ARB_FIXED      = 0;
   localparam int ARB_RR         = 1;

   localparam int DEF_NUM_CH     = 3;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_FIFO_DEPTH = 2;

   // Index width that stays legal for a single-element range.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/wb_arb_ctrl_if.sv
// Producer-side handshake and GPR write-port bundle of the write-back controller.
interface wb_arb_ctrl_if
   import wb_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
   logic [NUM_CH-1:0]            ch_valid;
   logic [NUM_CH-1:0]            ch_ready;
   logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
   logic [NUM_CH*ADDR_WIDTH-1:0] ch_rd;
   logic                         wr_valid_wb;
   logic [ADDR_WIDTH-1:0]        wr_addr_wb;
   logic [DATA_WIDTH-1:0]        wr_data_wb;
   logic [2**ADDR_WIDTH-1:0]     pending_rd_mask;
   logic                         wb_idle;

   modport master (
      output ch_valid, ch_data, ch_rd,
      input  ch_ready, wr_valid_wb, wr_addr_wb, wr_data_wb, pending_rd_mask, wb_idle
   );

   modport slave (
      input  ch_valid, ch_data, ch_rd,
      output ch_ready, wr_valid_wb, wr_addr_wb, wr_data_wb, pending_rd_mask, wb_idle
   );
endinterface

// File: rtl/wb_ch_fifo.sv
// Per-channel synchronous FIFO; also exposes each slot's tag bits so the owner can
// build an occupancy-based mask without reaching into the storage.
module wb_ch_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2,
   parameter int TAG_W = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              din,
   output logic [WIDTH-1:0]              dout,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(DEPTH):0]        count,
   output logic [DEPTH-1:0]              slot_vld,
   output logic [DEPTH-1:0][TAG_W-1:0]   slot_tag
);
   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PW-1:0]               wr_ptr, rd_ptr, off;
   logic                        do_push, do_pop;

   // A full FIFO refuses a push even when it pops in the same cycle.
   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      off      = '0;
      slot_vld = '0;
      slot_tag = '0;
      for (int j = 0; j < DEPTH; j++) begin
         off         = PW'(j) - rd_ptr;
         slot_vld[j] = ({1'b0, off} < count);
         slot_tag[j] = mem[j][WIDTH-1 -: TAG_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/wb_arb_ctrl.sv
// Write-back controller: per-producer FIFOs, one-write-per-cycle arbiter onto a
// registered GPR port, and a pending-destination mask for hazard stalls.
module wb_arb_ctrl
   import wb_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int ARB_MODE   = ARB_FIXED
) (
   input  logic          cpu_clk,
   input  logic          cpu_rst,
   wb_arb_ctrl_if.slave  bus
);
   localparam int EW   = ADDR_WIDTH + DATA_WIDTH;
   localparam int CHW  = idx_w(NUM_CH);
   localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
   localparam int NREG = 2**ADDR_WIDTH;

   logic [NUM_CH-1:0]                                full, empty, push, pop;
   logic [NUM_CH-1:0][CNTW-1:0]                      count;
   logic [NUM_CH-1:0][EW-1:0]                        head;
   logic [NUM_CH-1:0][FIFO_DEPTH-1:0]                slot_vld;
   logic [NUM_CH-1:0][FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] slot_tag;

   logic [CHW-1:0]        rr_ptr, gnt_idx, cand;
   logic                  gnt_vld;
   logic                  wr_valid;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NREG-1:0]       mask;

   assign bus.ch_ready = ~full;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [ADDR_WIDTH-1:0] rd;
      assign rd = bus.ch_rd[c*ADDR_WIDTH +: ADDR_WIDTH];
      // Writes to x0 are swallowed here so they never occupy a slot or the mask.
      assign push[c] = bus.ch_valid[c] && (rd != '0);

      wb_ch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH), .TAG_W(ADDR_WIDTH)) u_fifo (
         .clk      (cpu_clk),
         .rst      (cpu_rst),
         .push     (push[c]),
         .pop      (pop[c]),
         .din      ({rd, bus.ch_data[c*DATA_WIDTH +: DATA_WIDTH]}),
         .dout     (head[c]),
         .full     (full[c]),
         .empty    (empty[c]),
         .count    (count[c]),
         .slot_vld (slot_vld[c]),
         .slot_tag (slot_tag[c])
      );
   end

   // rr_ptr stays at zero in fixed mode, so one search loop serves both modes.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = CHW'((int'(rr_ptr) + k) % NUM_CH);
         if (!gnt_vld && !empty[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      pop = '0;
      if (gnt_vld)
         pop[gnt_idx] = 1'b1;
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         rr_ptr   <= '0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         wr_valid <= gnt_vld;
         if (gnt_vld) begin
            {wr_addr, wr_data} <= head[gnt_idx];
            if (ARB_MODE == ARB_RR)
               rr_ptr <= (gnt_idx == CHW'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   always_comb begin
      mask = '0;
      for (int c = 0; c < NUM_CH; c++)
         for (int j = 0; j < FIFO_DEPTH; j++)
            if (slot_vld[c][j])
               mask[slot_tag[c][j]] = 1'b1;
      if (wr_valid)
         mask[wr_addr] = 1'b1;
      mask[0] = 1'b0;
   end

   assign bus.wr_valid_wb     = wr_valid;
   assign bus.wr_addr_wb      = wr_addr;
   assign bus.wr_data_wb      = wr_data;
   assign bus.pending_rd_mask = mask;
   assign bus.wb_idle         = (count == '0) && !wr_valid;
endmodule
